// File: rtl/divisor_seq.sv
// divisor_seq: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Companion to the SOMASUB add/sub unit; consumes the same A/B operand format and
// reports zero/sinal flags in the same style.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request pulse, sampled only in IDLE
//   A        dividend (unsigned)
//   B        divisor (unsigned)
//   busy     high while the iteration (CALC) is running
//   done     one-cycle pulse marking Q/Rm/flags valid
//   Q        quotient
//   Rm       remainder
//   div_zero divisor was zero for the completed operation
//   zero     Q == 0 for the completed operation
//   sinal    Q[WIDTH-1] for the completed operation
module divisor_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Rm,
  output logic             div_zero,
  output logic             zero,
  output logic             sinal
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   p;      // partial remainder, one guard bit for the sign check
  logic [WIDTH-1:0] d;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] b_r;    // latched divisor
  logic [CW-1:0]    count;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] d_next;

  // One restoring step: shift in next dividend bit, trial-subtract, keep on no borrow.
  always_comb begin
    p_sh   = {p[WIDTH-1:0], d[WIDTH-1]};
    trial  = p_sh - {1'b0, b_r};
    q_bit  = ~trial[WIDTH];
    p_next = q_bit ? trial : p_sh;
    d_next = {d[WIDTH-2:0], q_bit};
  end

  // Control FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      p        <= '0;
      d        <= '0;
      b_r      <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Q        <= '0;
      Rm       <= '0;
      div_zero <= 1'b0;
      zero     <= 1'b0;
      sinal    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d   <= A;
            b_r <= B;
            p   <= '0;
            if (B != '0) begin
              count <= CW'(WIDTH);
              busy  <= 1'b1;
              state <= CALC;
            end else begin
              // Division by zero completes immediately with an all-ones quotient.
              Q        <= '1;
              Rm       <= A;
              div_zero <= 1'b1;
              zero     <= 1'b0;
              sinal    <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        CALC: begin
          p     <= p_next;
          d     <= d_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            Q        <= d_next;
            Rm       <= p_next[WIDTH-1:0];
            div_zero <= 1'b0;
            zero     <= (d_next == '0);
            sinal    <= d_next[WIDTH-1];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_seq.sv
// tb_divisor_seq: directed self-checking bench for divisor_seq (WIDTH=4).
module tb_divisor_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] Q;
  logic [3:0] Rm;
  logic       div_zero;
  logic       zero;
  logic       sinal;

  int n_cmp  = 0;
  int n_fail = 0;

  divisor_seq #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .Q        (Q),
    .Rm       (Rm),
    .div_zero (div_zero),
    .zero     (zero),
    .sinal    (sinal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called 1ns after an edge while IDLE; returns 1ns after the accepting edge E0.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Steps cycle by cycle until done; counts cycles and busy cycles, bounded.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc      = 0;
    busy_cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Moves past the DONE cycle back to IDLE and checks the pulse was single.
  task automatic finish_op(input string tag);
    @(posedge clk); #1;
    check(tag, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int bcyc;

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", 32'(Q), 32'd0);
    check("rst_rm", 32'(Rm), 32'd0);
    check("rst_flags", {29'd0, div_zero, zero, sinal}, 32'd0);

    // 13 / 3
    start_op(4'd13, 4'd3);
    check("13_3_busy_e0", 32'(busy), 32'd1);
    wait_done(cyc, bcyc);
    check("13_3_latency", 32'(cyc), 32'd4);
    check("13_3_busy_cycles", 32'(bcyc), 32'd4);
    check("13_3_busy_at_done", 32'(busy), 32'd0);
    check("13_3_q", 32'(Q), 32'd4);
    check("13_3_rm", 32'(Rm), 32'd1);
    check("13_3_flags", {29'd0, div_zero, zero, sinal}, 32'd0);
    finish_op("13_3_single_done");

    // 15 / 1, with output hold checked right after the new start
    start_op(4'd15, 4'd1);
    check("hold_q", 32'(Q), 32'd4);
    check("hold_rm", 32'(Rm), 32'd1);
    wait_done(cyc, bcyc);
    check("15_1_latency", 32'(cyc), 32'd4);
    check("15_1_q", 32'(Q), 32'd15);
    check("15_1_rm", 32'(Rm), 32'd0);
    check("15_1_sinal", 32'(sinal), 32'd1);
    check("15_1_zero", 32'(zero), 32'd0);
    finish_op("15_1_single_done");

    // 2 / 9
    start_op(4'd2, 4'd9);
    wait_done(cyc, bcyc);
    check("2_9_q", 32'(Q), 32'd0);
    check("2_9_rm", 32'(Rm), 32'd2);
    check("2_9_zero", 32'(zero), 32'd1);
    check("2_9_sinal", 32'(sinal), 32'd0);
    finish_op("2_9_single_done");

    // 7 / 0
    start_op(4'd7, 4'd0);
    check("7_0_done_e0", 32'(done), 32'd1);
    wait_done(cyc, bcyc);
    check("7_0_latency", 32'(cyc), 32'd0);
    check("7_0_busy", 32'(busy), 32'd0);
    check("7_0_q", 32'(Q), 32'd15);
    check("7_0_rm", 32'(Rm), 32'd7);
    check("7_0_dz", 32'(div_zero), 32'd1);
    finish_op("7_0_single_done");
    check("7_0_busy_after", 32'(busy), 32'd0);

    // 12 / 5 with a second start and operand change during CALC
    start_op(4'd12, 4'd5);
    @(posedge clk); #1;
    A     = 4'd9;
    B     = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc, bcyc);
    check("12_5_latency", 32'(cyc), 32'd2);
    check("12_5_q", 32'(Q), 32'd2);
    check("12_5_rm", 32'(Rm), 32'd2);
    check("12_5_dz", 32'(div_zero), 32'd0);
    finish_op("12_5_single_done");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("12_5_no_second_done", 32'(done), 32'd0);
      check("12_5_no_second_busy", 32'(busy), 32'd0);
    end

    // 14 / 3 aborted by reset after E2
    start_op(4'd14, 4'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q", 32'(Q), 32'd0);
    check("abort_rm", 32'(Rm), 32'd0);
    check("abort_flags", {29'd0, div_zero, zero, sinal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 32'd0);
    end
    start_op(4'd14, 4'd3);
    wait_done(cyc, bcyc);
    check("14_3_latency", 32'(cyc), 32'd4);
    check("14_3_q", 32'(Q), 32'd4);
    check("14_3_rm", 32'(Rm), 32'd2);
    finish_op("14_3_single_done");

    // Exhaustive sweep of all operand pairs
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(4'(a), 4'(b));
        wait_done(cyc, bcyc);
        if (b == 0) begin
          check("sweep_dz_latency", 32'(cyc), 32'd0);
          check("sweep_dz_flag", 32'(div_zero), 32'd1);
          check("sweep_dz_q", 32'(Q), 32'd15);
          check("sweep_dz_rm", 32'(Rm), 32'(a));
        end else begin
          check("sweep_latency", 32'(cyc), 32'd4);
          check("sweep_dz_clear", 32'(div_zero), 32'd0);
          check("sweep_invariant", 32'(int'(Q) * b + int'(Rm)), 32'(a));
          check("sweep_rm_lt_b", 32'(int'(Rm) < b), 32'd1);
          check("sweep_q", 32'(Q), 32'(a / b));
          check("sweep_zero", 32'(zero), 32'((a / b) == 0));
        end
        finish_op("sweep_single_done");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/divisor_seq.md
Name: divisor_seq

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the team's combinational add/sub unit (SOMASUB), consuming the same A/B operand format.
- Computes quotient and remainder one bit per clock using trial subtraction plus a sign check.
- Exposes the same zero/sinal flag style as SOMASUB so downstream logic can treat both units uniformly.
- Sits beside the add/sub unit in the datapath, with a start/done handshake toward the controller.

Parameters:
- WIDTH, 4, operand/quotient/remainder width in bits (legal: 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- A  input  WIDTH  dividend (unsigned).
- B  input  WIDTH  divisor (unsigned).
- busy  output  1  high while an operation is in progress (CALC state).
- done  output  1  one-cycle pulse marking Q/Rm/flags valid.
- Q  output  WIDTH  quotient.
- Rm  output  WIDTH  remainder.
- div_zero  output  1  set when B==0 for the completed operation.
- zero  output  1  Q==0 for the completed operation.
- sinal  output  1  Q[WIDTH-1] (MSB of quotient, SOMASUB flag convention).

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is asynchronous, active-low (rst_n low clears state immediately, independent of clk).
  - Reset values: state=IDLE; busy=0, done=0, Q=0, Rm=0, div_zero=0, zero=0, sinal=0; all internal registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 at edge E0, latch A and B.
  - If B!=0: partial remainder P(WIDTH+1 bits)=0, shift register D=A, count=WIDTH, go CALC.
  - If B==0: go DONE with Q=all ones, Rm=A, div_zero=1, done=1 at E0.
  - start=0: stay IDLE.
- CALC (edges E1..E_WIDTH, one iteration each):
  - P' = {P[WIDTH-1:0], D[MSB]}; D shifts left.
  - T = P' - {0,B}, computed WIDTH+1 bits wide.
  - If T[WIDTH]==0: P=T and new quotient bit = 1.
  - Else: P=P' (restore) and new quotient bit = 0.
  - Quotient bit shifts into the LSB of D.
  - count decrements.
  - On the iteration where count reaches 0 (edge E_WIDTH): load Q=D, Rm=P[WIDTH-1:0], div_zero=0; set zero and sinal from the new Q; done=1; go DONE.
- DONE: lasts exactly one cycle, then go IDLE with done=0.
- busy: 1 exactly while state==CALC; 0 in IDLE and DONE.
- Latency: done is high during the cycle after edge E_WIDTH for B!=0, and during the cycle after E0 for B==0.
- Output hold: Q, Rm, div_zero, zero and sinal hold their last completed values until the next completion. They do not change when a new start is accepted.
- start handling: start while busy or in DONE is ignored (not queued). A and B changes during CALC have no effect because operands are latched.
- Reset mid-operation: the operation is aborted, all outputs return to reset values, no done pulse is produced.
- Invariant when div_zero=0: A == Q*B + Rm and Rm < B.
- No overflow output: an unsigned quotient always fits WIDTH bits.

Test Plan:
- WIDTH=4, rst_n low, then release → all outputs 0; busy=0.
- A=13, B=3, start pulse at E0 → busy high E0..E4; done single pulse after E4; Q=4, Rm=1, zero=0, sinal=0, div_zero=0.
- A=15, B=1 → Q=15, Rm=0, sinal=1. Then A=2, B=9 → Q=0, Rm=2, zero=1.
- A=7, B=0 → done one cycle after E0; Q=15, Rm=7, div_zero=1, busy never asserted.
- A=12, B=5 started; at E2 assert start with A=9, B=3 and change A/B → second start ignored; result Q=2, Rm=2; only one done pulse.
- A=14, B=3 started; pull rst_n low after E2 → outputs immediately 0, no done pulse. After release, a new start with A=14, B=3 gives Q=4, Rm=2. Finish with an exhaustive sweep over all 256 A/B pairs checking the invariant.
